// File: rtl/program_loader.sv
// Framed byte-stream loader: takes HEADER/addr/len/data/chk frames over valid/ready
// and writes the payload into program memory, holding the CPU until a frame checks good.
module program_loader #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              inValid,
  input  logic [7:0]        inData,
  output logic              inReady,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memDataWrite,
  output logic              memWriteStrobe,
  output logic              cpuHold,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves on a posedge where inValid && inReady; inReady is
  // low only in WRITE, so the source may hold inValid high and stream freely.
  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CHK} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_reg, addr_n;
  logic [8:0]        count, count_n;
  logic [7:0]        sum, sum_n, chk_sum;
  logic              ready_n, strobe_n, done_n, error_n, hold_n;
  logic [ADDR_W-1:0] maddr_n;
  logic [7:0]        mdata_n;
  logic              accept;

  assign accept    = inValid & inReady;
  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    addr_n   = addr_reg;
    count_n  = count;
    sum_n    = sum;
    strobe_n = 1'b0;
    maddr_n  = memAddr;
    mdata_n  = memDataWrite;
    done_n   = 1'b0;
    error_n  = error;
    hold_n   = cpuHold;
    chk_sum  = sum + inData;
    case (state)
      IDLE: if (accept && inData == HEADER) begin
        state_n = ADDR;
        sum_n   = 8'd0;
        error_n = 1'b0;
        hold_n  = 1'b1;
      end
      ADDR: if (accept) begin
        addr_n  = ADDR_W'(inData);
        sum_n   = inData;
        state_n = LEN;
      end
      LEN: if (accept) begin
        count_n = (inData == 8'd0) ? 9'd256 : {1'b0, inData};
        sum_n   = chk_sum;
        state_n = DATA;
      end
      DATA: if (accept) begin
        // Write outputs are registered here so they are valid throughout WRITE.
        sum_n    = chk_sum;
        count_n  = count - 9'd1;
        strobe_n = 1'b1;
        maddr_n  = addr_reg;
        mdata_n  = inData;
        state_n  = WRITE;
      end
      WRITE: begin
        addr_n  = addr_reg + ADDR_W'(1);
        state_n = (count == 9'd0) ? CHK : DATA;
      end
      CHK: if (accept) begin
        if (chk_sum == 8'd0) begin
          done_n = 1'b1;
          hold_n = 1'b0;
        end else begin
          error_n = 1'b1;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n != WRITE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      addr_reg       <= '0;
      count          <= 9'd0;
      sum            <= 8'd0;
      inReady        <= 1'b0;
      memAddr        <= '0;
      memDataWrite   <= 8'd0;
      memWriteStrobe <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      cpuHold        <= 1'b1;
    end else begin
      state          <= state_n;
      addr_reg       <= addr_n;
      count          <= count_n;
      sum            <= sum_n;
      inReady        <= ready_n;
      memAddr        <= maddr_n;
      memDataWrite   <= mdata_n;
      memWriteStrobe <= strobe_n;
      done           <= done_n;
      error          <= error_n;
      cpuHold        <= hold_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model feeds expected writes and
// frame outcomes into queues; a negedge monitor pops and compares what the DUT emits.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       resetN;
  logic       inValid;
  logic [7:0] inData;
  logic       inReady;
  logic [7:0] memAddr;
  logic [7:0] memDataWrite;
  logic       memWriteStrobe;
  logic       cpuHold;
  logic       done;
  logic       error;
  logic [2:0] state_dbg;

  program_loader dut (
    .clk(clk), .resetN(resetN), .inValid(inValid), .inData(inData),
    .inReady(inReady), .memAddr(memAddr), .memDataWrite(memDataWrite),
    .memWriteStrobe(memWriteStrobe), .cpuHold(cpuHold), .done(done),
    .error(error), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];   // {addr, data} of each expected write
  logic        res_q[$];   // 1 = good frame (done), 0 = bad frame (error)
  logic [7:0]  payload[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        ready_chk_en = 1'b0;
  logic        prev_error = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: writes, frame outcomes and the one-cycle inReady gap.
  always @(negedge clk) begin
    if (resetN === 1'b1) begin
      if (memWriteStrobe) begin
        if (exp_q.size() == 0) check("unexpected_strobe", {memAddr, memDataWrite}, 32'hFFFF_FFFF);
        else check("write", {memAddr, memDataWrite}, exp_q.pop_front());
      end
      if (ready_chk_en) check("ready_vs_write", inReady, !memWriteStrobe);
      if (done) begin
        if (res_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_for_good_frame", 1, res_q.pop_front());
        check("hold_low_with_done", cpuHold, 0);
      end
      if (error && !prev_error) begin
        if (res_q.size() == 0) check("unexpected_error", 1, 0);
        else check("error_for_bad_frame", 0, res_q.pop_front());
        check("hold_high_on_error", cpuHold, 1);
      end
    end
    prev_error = error;
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit accepted = 0;
    int guard = 0;
    while (!accepted) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        inValid = 1'b0;
        inData  = 8'($urandom);
      end else begin
        inValid = 1'b1;
        inData  = b;
      end
      accepted = inValid && inReady;
      @(posedge clk);
      guard++;
      if (guard > 200) begin
        check("send_timeout", 0, 1);
        accepted = 1;
      end
    end
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Reference model: expected writes are start+i mod 256, and the frame is good
  // when the byte sum after HEADER is 0 mod 256.
  task automatic do_frame(input logic [7:0] start, input logic [7:0] len,
                          input logic [7:0] chk, input bit gaps);
    int n = (len == 0) ? 256 : len;
    int s = start + len + chk;
    bit good;
    for (int i = 0; i < n; i++) begin
      s += payload[i];
      exp_q.push_back({8'(start + i), payload[i]});
    end
    good = ((s % 256) == 0);
    res_q.push_back(good);
    send_byte(8'hA5, gaps);
    send_byte(start, gaps);
    send_byte(len, gaps);
    for (int i = 0; i < n; i++) send_byte(payload[i], gaps);
    send_byte(chk, gaps);
    repeat (3) @(negedge clk);
    check("hold_after_frame", cpuHold, good ? 0 : 1);
    check("error_after_frame", error, good ? 0 : 1);
    check("writes_drained", exp_q.size(), 0);
    check("result_drained", res_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inReady"}, inReady, 0);
    check({tag, "_memAddr"}, memAddr, 0);
    check({tag, "_memData"}, memDataWrite, 0);
    check({tag, "_strobe"}, memWriteStrobe, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_cpuHold"}, cpuHold, 1);
  endtask

  task automatic set_payload3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    payload = {};
    payload.push_back(a);
    payload.push_back(b);
    payload.push_back(c);
  endtask

  initial begin
    resetN  = 1'b0;
    inValid = 1'b0;
    inData  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    resetN = 1'b1;
    @(negedge clk);
    check("ready_after_release", inReady, 1);
    ready_chk_en = 1'b1;

    // Basic good frame, then bad chk, then good again.
    set_payload3(8'h0C, 8'h0A, 8'h1C);
    do_frame(8'h10, 8'h03, 8'hBB, 0);
    do_frame(8'h10, 8'h03, 8'hBA, 0);
    do_frame(8'h10, 8'h03, 8'hBB, 0);

    // Address wrap FE -> FF -> 00.
    set_payload3(8'h11, 8'h22, 8'h33);
    do_frame(8'hFE, 8'h03, 8'h99, 0);

    // len = 0 means 256 bytes.
    payload = {};
    for (int i = 0; i < 256; i++) payload.push_back(8'h01);
    do_frame(8'h00, 8'h00, 8'h00, 0);

    // Leading garbage and random valid gaps.
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 1);
    set_payload3(8'h0C, 8'h0A, 8'h1C);
    do_frame(8'h10, 8'h03, 8'hBB, 1);

    // Random frames, some with a corrupted checksum.
    for (int f = 0; f < 6; f++) begin
      logic [7:0] st, ln, ck;
      int s;
      st = 8'($urandom);
      ln = 8'($urandom_range(1, 8));
      payload = {};
      s = st + ln;
      for (int i = 0; i < ln; i++) begin
        payload.push_back(8'($urandom));
        s += payload[i];
      end
      ck = 8'(256 - (s % 256));
      if ($urandom_range(0, 1) == 1) ck = ck + 8'($urandom_range(1, 255));
      do_frame(st, ln, ck, f[0]);
    end

    // Reset in the middle of DATA of a second frame.
    set_payload3(8'h0C, 8'h0A, 8'h1C);
    do_frame(8'h10, 8'h03, 8'hBB, 0);
    exp_q.push_back({8'h20, 8'hD0});
    exp_q.push_back({8'h21, 8'hD1});
    send_byte(8'hA5, 0);
    send_byte(8'h20, 0);
    send_byte(8'h05, 0);
    send_byte(8'hD0, 0);
    send_byte(8'hD1, 0);
    repeat (2) @(negedge clk);
    check("partial_writes_seen", exp_q.size(), 0);
    ready_chk_en = 1'b0;
    #2 resetN = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    ready_chk_en = 1'b1;
    set_payload3(8'h0C, 8'h0A, 8'h1C);
    do_frame(8'h10, 8'h03, 8'hBB, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
